// File: rtl/fir_lpf_serial.sv
// Single-MAC serial FIR low-pass filter. Each rising edge of clk_20k captures one
// sample into a circular delay line, then TAPS products are accumulated one per clock.
module fir_lpf_serial #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int TAPS = 16,
  parameter int OW   = DW + CW + $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_20k,
  input  logic signed [DW-1:0]    din,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]    coef_data,
  output logic signed [OW-1:0]    dout,
  output logic                    dout_valid,
  output logic                    busy,
  output logic                    overrun
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DW + CW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                state_q, state_d;
  logic                  clk_20k_prev_q, clk_20k_prev_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         k_q, k_d;
  logic signed [OW-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overrun_q, overrun_d;
  logic signed [DW-1:0]  delay_q [TAPS];
  logic signed [DW-1:0]  delay_d [TAPS];
  logic signed [CW-1:0]  coef_q  [TAPS];
  logic signed [CW-1:0]  coef_d  [TAPS];

  logic                  tick, busy_w, coef_wr;
  logic [AW-1:0]         rd_idx;
  logic signed [PW-1:0]  prod;

  assign tick    = clk_20k & ~clk_20k_prev_q;
  assign busy_w  = (state_q != IDLE);
  assign coef_wr = coef_we & ~busy_w & ~tick;

  // wptr already points past the newest sample once MAC starts
  assign rd_idx  = wptr_q - AW'(1) - k_q;
  assign prod    = coef_q[k_q] * delay_q[rd_idx];

  always_comb begin
    state_d        = state_q;
    clk_20k_prev_d = clk_20k;
    wptr_d         = wptr_q;
    k_d            = k_q;
    acc_d          = acc_q;
    dout_d         = dout_q;
    dout_valid_d   = 1'b0;
    overrun_d      = overrun_q | (tick & busy_w);
    delay_d        = delay_q;
    coef_d         = coef_q;
    if (coef_wr) coef_d[coef_addr] = coef_data;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          delay_d[wptr_q] = din;
          wptr_d          = wptr_q + AW'(1);
          acc_d           = '0;
          k_d             = '0;
          state_d         = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + OW'(prod);
        k_d   = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) state_d = DONE;
      end
      DONE: begin
        dout_d       = acc_q;
        dout_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Edge register resets high so a level already high at release is not a capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      clk_20k_prev_q <= 1'b1;
      wptr_q         <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      clk_20k_prev_q <= clk_20k_prev_d;
      wptr_q         <= wptr_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      overrun_q      <= overrun_d;
      delay_q        <= delay_d;
      coef_q         <= coef_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_w;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fir_lpf_serial.sv
// Scoreboard bench for fir_lpf_serial: driver models captures as a dot product over
// sample history and queues expected outputs; a negedge monitor pops and compares.
module tb_fir_lpf_serial;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 16;
  localparam int AW   = $clog2(TAPS);
  localparam int OW   = DW + CW + AW;

  logic                 clk;
  logic                 rst;
  logic                 clk_20k;
  logic signed [DW-1:0] din;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [OW-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 overrun;

  fir_lpf_serial #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .clk_20k(clk_20k), .din(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint val; int cyc; } exp_t;
  exp_t exp_q[$];

  // reference state, as of the most recent clock edge
  logic signed [CW-1:0] cm [TAPS];
  logic signed [DW-1:0] xh [TAPS];   // xh[0] = newest accepted sample
  int  ecnt = 0;
  int  cap_cyc = 0;
  bit  have_cap = 0;
  bit  ovr_m = 0;
  bit  prev_lvl = 1;
  bit  rst_at = 0;
  longint last_dout = 0;
  int  n_pass = 0;
  int  n_tot = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, ecnt);
  endtask

  function automatic longint fir_sum();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(cm[k]) * longint'(xh[k]);
    return s;
  endfunction

  // Advance one clock and apply what the filter rules say happens at that edge
  task automatic step();
    bit tk, bz;
    @(posedge clk);
    ecnt++;
    rst_at = rst;
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin xh[k] = '0; cm[k] = '0; end
      prev_lvl = 1; have_cap = 0; ovr_m = 0;
      exp_q.delete();
    end else begin
      tk = clk_20k && !prev_lvl;
      bz = have_cap && ((ecnt - cap_cyc) <= TAPS + 1);
      if (tk && bz) ovr_m = 1;
      else if (tk) begin
        for (int k = TAPS - 1; k > 0; k--) xh[k] = xh[k-1];
        xh[0] = din;
        cap_cyc = ecnt;
        have_cap = 1;
        exp_q.push_back('{fir_sum(), ecnt + TAPS + 1});
      end
      if (coef_we && !bz && !tk) cm[coef_addr] = coef_data;
      prev_lvl = clk_20k;
    end
    #1;
  endtask

  task automatic pulse(input logic signed [DW-1:0] d, input int hi, input int lo);
    din = d; clk_20k = 1;
    repeat (hi) step();
    clk_20k = 0;
    repeat (lo) step();
  endtask

  task automatic wr(input int a, input int v);
    coef_we = 1; coef_addr = AW'(a); coef_data = CW'(v);
    step();
    coef_we = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   bm;
    if (ecnt > 0) begin
      if (rst_at) begin
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        last_dout = 0;
      end else begin
        bm = have_cap && ((ecnt - cap_cyc) <= TAPS);
        chk("busy", busy, bm);
        chk("overrun", overrun, ovr_m);
        if (dout_valid) begin
          if (exp_q.size() == 0) chk("unexpected_valid", dout_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("dout", dout, e.val);
            chk("latency_edge", ecnt, e.cyc);
            last_dout = e.val;
          end
        end else begin
          chk("dout_hold", dout, last_dout);
          if (exp_q.size() > 0 && exp_q[0].cyc < ecnt) begin
            chk("missing_valid", dout_valid, 1);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1; clk_20k = 1; din = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    repeat (3) step();
    // level held high across reset release must not capture
    rst = 0;
    repeat (10) step();
    clk_20k = 0;
    repeat (3) step();

    // impulse through ramp coefficients
    for (int k = 0; k < TAPS; k++) wr(k, k + 1);
    pulse(100, 3, 37);
    repeat (19) pulse(0, 3, 37);

    // DC step with the 500-cycle rate generator
    for (int k = 0; k < TAPS; k++) wr(k, 1);
    repeat (18) pulse(1000, 250, 250);

    // full-scale negative, accumulates to 2^34
    for (int k = 0; k < TAPS; k++) wr(k, -32768);
    repeat (17) pulse(-32768, 3, 27);

    // coefficient writes while busy are dropped; idle writes apply next sample
    for (int k = 0; k < TAPS; k++) wr(k, 1);
    din = 7; clk_20k = 1; step();
    coef_we = 1; coef_addr = '0; coef_data = 5;
    repeat (3) step();
    coef_we = 0; clk_20k = 0;
    repeat (25) step();
    pulse(9, 2, 25);
    wr(0, 5);
    pulse(9, 2, 25);

    // second edge 5 clocks after the first is an overrun
    pulse(11, 2, 3);
    pulse(22, 2, 40);
    pulse(33, 2, 30);

    // reset 8 clocks into MAC abandons the result and clears overrun
    din = 44; clk_20k = 1; step();
    clk_20k = 0;
    repeat (7) step();
    rst = 1; step();
    rst = 0;
    repeat (30) step();

    // random samples, spacing, and coefficient writes
    for (int k = 0; k < TAPS; k++) wr(k, int'($urandom_range(0, 65535)));
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        coef_we = 1; coef_addr = AW'($urandom); coef_data = CW'($urandom);
      end
      pulse(DW'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 30)));
      coef_we = 0;
    end

    clk_20k = 0;
    repeat (40) step();
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
